// File: rtl/inst_fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch front end.
// - fetch_state_e : bus sequencing FSM states
// - fetch_entry_t : one buffered fetch result {pc, inst, adel}
// - RESET_PC_DEFAULT, SRAM_SIZE_WORD : reset fetch address and sram-like word size code
package inst_fetch_buffer_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
    localparam logic [1:0]  SRAM_SIZE_WORD   = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StHalt = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// Instruction-side sram-like bus.
// master: initiator (fetch unit) drives req/wr/size/addr/wdata, receives addr_ok/data_ok/rdata.
// slave : memory bridge, the mirror image.
interface inst_fetch_buffer_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/inst_fetch_buffer_fetch_fifo.sv
// DEPTH-entry FIFO of fetch results.
// Ports: clk/resetn; push_i + push_entry_i write the tail; pop_i advances the head;
// flush_i empties the FIFO and wins over a same-cycle push; count_o is the occupancy;
// head_o is the oldest entry (stale contents when empty).
module fetch_fifo
    import inst_fetch_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_i,
    input  fetch_entry_t  push_entry_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t  head_o
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;

    assign pop_ok = pop_i && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            // Pointers return to slot 0 so the head only moves on flush, pop or push-to-empty.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_entry_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_i) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch front end: sequences PC+4 over the sram-like bus (one outstanding
// transaction), buffers returned words with their PCs and hands them to decode.
// Ports:
//   clk, resetn               : clock, asynchronous active-low reset
//   inst_bus (master)         : instruction sram-like bus
//   redirect_valid/_pc        : flush the buffer and refetch from redirect_pc
//   id_ready                  : decoder takes the head entry
//   if_valid/if_inst/if_pc/if_adel : head entry; if_adel marks a misaligned-fetch exception
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    inst_fetch_buffer_if.master  inst_bus,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    input  logic                 id_ready,
    output logic                 if_valid,
    output logic [31:0]          if_inst,
    output logic [31:0]          if_pc,
    output logic                 if_adel
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          discard_q, discard_d;
    logic          req_q, req_d;

    logic          push;
    fetch_entry_t  push_entry;
    logic          pop;
    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;
    logic          space;
    fetch_entry_t  head;

    // An in-flight read already owns a slot, so it counts against the buffer.
    assign occupancy = count + CW'(state_q == StWait);
    assign space     = occupancy < CW'(DEPTH);
    assign pop       = if_valid && id_ready && !redirect_valid;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        push       = 1'b0;
        push_entry = '0;

        unique case (state_q)
            StIdle: begin
                if (space) begin
                    if (fetch_pc_q[1:0] == 2'b00) begin
                        state_d = StReq;
                    end else begin
                        push       = 1'b1;
                        push_entry = '{pc: fetch_pc_q, inst: 32'h0, adel: 1'b1};
                        state_d    = StHalt;
                    end
                end
            end
            StReq: begin
                if (inst_bus.inst_addr_ok) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (inst_bus.inst_data_ok) begin
                    if (!discard_q) begin
                        push       = 1'b1;
                        push_entry = '{pc: fetch_pc_q - 32'd4, inst: inst_bus.inst_rdata,
                                       adel: 1'b0};
                    end
                    discard_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            StHalt: ;
            default: state_d = StIdle;
        endcase

        if (redirect_valid) begin
            push       = 1'b0;
            fetch_pc_d = redirect_pc;
            unique case (state_q)
                StReq: begin
                    if (inst_bus.inst_addr_ok) begin
                        state_d   = StWait;
                        discard_d = 1'b1;
                    end else if (redirect_pc[1:0] != 2'b00) begin
                        // Unaccepted request may be withdrawn; IDLE raises the AdEL entry.
                        state_d = StIdle;
                    end else begin
                        state_d = StReq;
                    end
                end
                StWait: begin
                    if (inst_bus.inst_data_ok) begin
                        state_d   = StIdle;
                        discard_d = 1'b0;
                    end else begin
                        state_d   = StWait;
                        discard_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        req_d = (state_d == StReq);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            req_q      <= req_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .count_o      (count),
        .head_o       (head)
    );

    assign inst_bus.inst_req   = req_q;
    assign inst_bus.inst_wr    = 1'b0;
    assign inst_bus.inst_size  = SRAM_SIZE_WORD;
    assign inst_bus.inst_addr  = fetch_pc_q;
    assign inst_bus.inst_wdata = 32'h0;

    assign if_valid = (count != '0);
    assign if_inst  = head.inst;
    assign if_pc    = head.pc;
    assign if_adel  = head.adel;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
`timescale 1ns/1ps
module tb_inst_fetch_buffer;
    import inst_fetch_buffer_pkg::*;

    logic        clk;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_adel;

    inst_fetch_buffer_if bus ();

    inst_fetch_buffer #(
        .RESET_PC (32'hbfc0_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst_bus       (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_adel        (if_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5a5a_a5a5;
    endfunction

    // ---------------- bus responder (drives at negedge+1) ----------------
    int          addr_lat = 1;
    int          data_lat = 1;
    int          acnt = 0;
    int          dcnt = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr;
    bit          use_override = 1'b0;
    logic [31:0] override_data = 32'h1234_5678;
    logic [31:0] acc_q [$];

    always @(negedge clk) begin
        #1;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        if (!resetn) begin
            pend = 1'b0;
            acnt = 0;
            dcnt = 0;
        end else if (pend) begin
            dcnt++;
            if (dcnt >= data_lat) begin
                bus.inst_data_ok = 1'b1;
                bus.inst_rdata   = use_override ? override_data : word_at(pend_addr);
                pend             = 1'b0;
            end
        end else if (bus.inst_req) begin
            acnt++;
            if (acnt >= addr_lat) begin
                bus.inst_addr_ok = 1'b1;
                pend      = 1'b1;
                pend_addr = bus.inst_addr;
                dcnt      = 0;
                acnt      = 0;
                // Acceptances in a redirect cycle belong to the abandoned stream.
                if (!redirect_valid) acc_q.push_back(bus.inst_addr);
            end
        end
    end

    // ---------------- scoreboard monitor (samples at negedge+3) ----------------
    fetch_entry_t sb_q [$];

    always @(negedge clk) begin
        #3;
        if (resetn && if_valid && id_ready && !redirect_valid) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pop: got pc=%h inst=%h adel=%b expected no entry",
                         if_pc, if_inst, if_adel);
            end else begin
                fetch_entry_t e;
                e = sb_q.pop_front();
                if ({if_pc, if_inst, if_adel} !== e) begin
                    bad++;
                    $display("FAIL pop_entry: got pc=%h inst=%h adel=%b expected pc=%h inst=%h adel=%b",
                             if_pc, if_inst, if_adel, e.pc, e.inst, e.adel);
                end
            end
        end
    end

    // ---------------- stimulus helpers (drive at negedge+0) ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        resetn         = 1'b0;
        repeat (2) tick();
        sb_q.delete();
        acc_q.delete();
        resetn = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        sb_q.delete();
        acc_q.delete();
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] pc);
        sb_q.push_back({pc, word_at(pc), 1'b0});
    endtask

    task automatic wait_sb_empty(input string name, input int budget);
        int i = 0;
        while (sb_q.size() != 0 && i < budget) begin
            tick();
            i++;
        end
        check(name, sb_q.size(), 0);
    endtask

    task automatic wait_acc(input string name, input int n, input int budget);
        int i = 0;
        while (acc_q.size() < n && i < budget) begin
            tick();
            i++;
        end
        check(name, (acc_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [31:0] target;
        int          a_lat;
        int          d_lat;
        int          n_words;
        bit          adel;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        bit found;

        vecs[0] = '{32'h8000_0000, 1, 1, 3, 1'b0};
        vecs[1] = '{32'h9fc0_0010, 2, 3, 3, 1'b0};
        vecs[2] = '{32'hffff_fff8, 1, 4, 3, 1'b0};  // PC wraps through zero
        vecs[3] = '{32'h8000_0001, 1, 1, 1, 1'b1};

        resetn           = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        id_ready         = 1'b0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;

        // Reset state
        repeat (2) tick();
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_inst_req", 32'(bus.inst_req), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_if_adel", 32'(if_adel), 32'd0);
        check("rst_inst_addr", bus.inst_addr, 32'hbfc0_0000);
        check("tie_inst_size", 32'(bus.inst_size), 32'd2);
        check("tie_inst_wr", 32'(bus.inst_wr), 32'd0);

        // Sequential fetch, single-cycle bus
        do_reset();
        addr_lat = 1;
        data_lat = 1;
        expect_word(32'hbfc0_0000);
        expect_word(32'hbfc0_0004);
        expect_word(32'hbfc0_0008);
        id_ready = 1'b1;
        wait_sb_empty("seq_pops", 60);
        id_ready = 1'b0;
        check("seq_addr0", acc_q[0], 32'hbfc0_0000);
        check("seq_addr1", acc_q[1], 32'hbfc0_0004);
        check("seq_addr2", acc_q[2], 32'hbfc0_0008);

        // Backpressure: buffer fills to DEPTH and requests stop
        do_reset();
        repeat (20) tick();
        check("full_if_valid", 32'(if_valid), 32'd1);
        check("full_if_pc", if_pc, 32'hbfc0_0000);
        check("full_if_inst", if_inst, word_at(32'hbfc0_0000));
        check("full_req_count", acc_q.size(), 2);
        hits = 0;
        repeat (10) begin
            tick();
            if (bus.inst_req) hits++;
        end
        check("full_no_req", hits, 0);
        expect_word(32'hbfc0_0000);
        expect_word(32'hbfc0_0004);
        expect_word(32'hbfc0_0008);
        id_ready = 1'b1;
        wait_sb_empty("drain_pops", 60);
        id_ready = 1'b0;
        check("drain_resume_addr", acc_q[2], 32'hbfc0_0008);

        // Redirect while waiting for data: returned word must be dropped
        do_reset();
        addr_lat     = 1;
        data_lat     = 4;
        use_override = 1'b1;
        id_ready     = 1'b1;
        wait_acc("wait_first_acc", 1, 20);
        redirect(32'h8000_0000);
        hits = 0;
        for (int i = 0; i < 30 && acc_q.size() == 0; i++) begin
            tick();
            if (if_valid) hits++;
        end
        use_override = 1'b0;
        check("wait_redir_no_valid", hits, 0);
        check("wait_redir_addr", acc_q[0], 32'h8000_0000);
        expect_word(32'h8000_0000);
        wait_sb_empty("wait_redir_pop", 40);
        id_ready = 1'b0;

        // Redirect in the cycle bfc00004 is accepted
        do_reset();
        addr_lat = 1;
        data_lat = 1;
        id_ready = 1'b1;
        expect_word(32'hbfc0_0000);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (bus.inst_req && bus.inst_addr == 32'hbfc0_0004) found = 1'b1;
        end
        check("aok_found_req", 32'(found), 32'd1);
        redirect(32'h8000_0000);
        expect_word(32'h8000_0000);
        expect_word(32'h8000_0004);
        wait_sb_empty("aok_redir_pops", 60);
        id_ready = 1'b0;
        check("aok_redir_addr", acc_q[0], 32'h8000_0000);

        // Misaligned redirect: AdEL entry, no bus access, HALT until next redirect
        repeat (15) tick();
        redirect(32'h8000_0002);
        hits = 0;
        repeat (8) begin
            tick();
            if (bus.inst_req) hits++;
        end
        check("adel_no_req", hits, 0);
        check("adel_no_acc", acc_q.size(), 0);
        check("adel_if_valid", 32'(if_valid), 32'd1);
        check("adel_if_pc", if_pc, 32'h8000_0002);
        check("adel_if_adel", 32'(if_adel), 32'd1);
        check("adel_if_inst", if_inst, 32'h0);
        redirect(32'h8000_0100);
        expect_word(32'h8000_0100);
        expect_word(32'h8000_0104);
        id_ready = 1'b1;
        wait_sb_empty("adel_recover_pops", 60);
        id_ready = 1'b0;
        check("adel_recover_addr", acc_q[0], 32'h8000_0100);

        // Asynchronous reset mid-WAIT with one entry buffered
        do_reset();
        addr_lat = 1;
        data_lat = 3;
        wait_acc("rst_mid_acc", 2, 40);
        check("rst_mid_pre_valid", 32'(if_valid), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_if_valid", 32'(if_valid), 32'd0);
        check("rst_mid_inst_req", 32'(bus.inst_req), 32'd0);
        check("rst_mid_if_pc", if_pc, 32'h0);
        repeat (2) tick();
        acc_q.delete();
        sb_q.delete();
        resetn = 1'b1;
        wait_acc("rst_mid_refetch", 1, 20);
        check("rst_mid_first_addr", acc_q[0], 32'hbfc0_0000);

        // Table of redirect targets and bus latencies
        for (int v = 0; v < 4; v++) begin
            id_ready = 1'b0;
            repeat (15) tick();
            addr_lat = vecs[v].a_lat;
            data_lat = vecs[v].d_lat;
            redirect(vecs[v].target);
            for (int k = 0; k < vecs[v].n_words; k++) begin
                if (vecs[v].adel) sb_q.push_back({vecs[v].target, 32'h0, 1'b1});
                else expect_word(vecs[v].target + 32'(4 * k));
            end
            id_ready = 1'b1;
            wait_sb_empty($sformatf("vec%0d_pops", v), 80);
            id_ready = 1'b0;
            if (vecs[v].adel) check($sformatf("vec%0d_no_acc", v), acc_q.size(), 0);
            else check($sformatf("vec%0d_first_addr", v), acc_q[0], vecs[v].target);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
